// File: rtl/piso_share_ctrl.sv
// piso_share_ctrl: round-robin sharing of one PISO shift register between two requesters
module piso_share_ctrl #(
    parameter int N       = 4,
    parameter int BIT_DIV = 4
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic [1:0]   req,
    input  logic [N-1:0] data0,
    input  logic [N-1:0] data1,
    output logic [1:0]   ack,
    output logic [N-1:0] piso_data,
    output logic         piso_en,
    output logic         piso_shift,
    output logic         frame,
    output logic         src,
    output logic         busy
);
    localparam int DW = BIT_DIV > 1 ? $clog2(BIT_DIV) : 1;
    localparam int BW = $clog2(N);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic div_last, bit_last, winner;
    assign div_last = div_cnt == DIV_LAST;
    assign bit_last = bit_cnt == BIT_LAST;
    // src doubles as the registered grant; on a tie the other requester wins
    assign winner = &req ? ~src : req[1];
    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            state   <= IDLE;
            src     <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |req)
                src <= winner;
            if (state != SHIFT || (div_last && bit_last)) begin
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (div_last) begin
                div_cnt <= '0;
                bit_cnt <= bit_cnt + 1'b1;
            end else
                div_cnt <= div_cnt + 1'b1;
        end
    always_comb begin
        state_nxt  = state;
        state_nxt  = state == IDLE ? (|req ? LOAD : IDLE) :
                     state == LOAD ? SHIFT :
                     (div_last && bit_last) ? IDLE : SHIFT;
        piso_shift = state == SHIFT && div_last && !bit_last;
        piso_en    = state == LOAD || piso_shift;
        ack        = state == LOAD ? (src ? 2'b10 : 2'b01) : 2'b00;
        frame      = state == SHIFT;
        busy       = state != IDLE;
        piso_data  = busy ? (src ? data1 : data0) : '0;
    end
endmodule

// File: tb/tb_piso_share_ctrl.sv
// tb_piso_share_ctrl: directed checks of piso_share_ctrl driving a behavioural PISO
module tb_piso_share_ctrl;
    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;
    logic [1:0] req_a = '0, req_b = '0;
    logic [3:0] d0_a = '0, d1_a = '0, d0_b = '0, d1_b = '0;
    logic [1:0] ack_a, ack_b;
    logic [3:0] pd_a, pd_b;
    logic en_a, sh_a, frame_a, src_a, busy_a;
    logic en_b, sh_b, frame_b, src_b, busy_b;
    piso_share_ctrl #(.N(4), .BIT_DIV(2)) u_dut (
        .clk(clk), .n_reset(n_reset), .req(req_a), .data0(d0_a), .data1(d1_a),
        .ack(ack_a), .piso_data(pd_a), .piso_en(en_a), .piso_shift(sh_a),
        .frame(frame_a), .src(src_a), .busy(busy_a));
    piso_share_ctrl #(.N(4), .BIT_DIV(1)) u_dut1 (
        .clk(clk), .n_reset(n_reset), .req(req_b), .data0(d0_b), .data1(d1_b),
        .ack(ack_b), .piso_data(pd_b), .piso_en(en_b), .piso_shift(sh_b),
        .frame(frame_b), .src(src_b), .busy(busy_b));
    logic [3:0] sr_a, sr_b;
    always @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            sr_a <= '0;
            sr_b <= '0;
        end else begin
            if (en_a) sr_a <= sh_a ? sr_a >> 1 : pd_a;
            if (en_b) sr_b <= sh_b ? sr_b >> 1 : pd_b;
        end
    logic sel = 1'b0;
    logic [1:0] m_ack;
    logic [3:0] m_pd;
    logic m_en, m_sh, m_frame, m_src, m_busy, m_sout;
    assign m_ack   = sel ? ack_b : ack_a;
    assign m_pd    = sel ? pd_b : pd_a;
    assign m_en    = sel ? en_b : en_a;
    assign m_sh    = sel ? sh_b : sh_a;
    assign m_frame = sel ? frame_b : frame_a;
    assign m_src   = sel ? src_b : src_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_sout  = sel ? sr_b[0] : sr_a[0];
    int n_cmp = 0, n_err = 0;
    int gap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (m_ack == 2'b00 && n < 8);
        chk("load_seen", 32'(m_ack != 2'b00), 1);
    endtask

    task automatic expect_frame(input string tag, input logic [3:0] word, input logic owner,
                                input logic toggle, input logic hold, output int g);
        int pulses, bd;
        bd = sel ? 1 : 2;
        pulses = 0;
        wait_load(g);
        chk($sformatf("%s_ack", tag), 32'(m_ack), owner ? 2 : 1);
        chk($sformatf("%s_ldata", tag), 32'(m_pd), 32'(word));
        chk($sformatf("%s_lden", tag), 32'({m_en, m_sh}), 2);
        chk($sformatf("%s_lsrc", tag), 32'(m_src), 32'(owner));
        if (!hold) begin
            if (sel) req_b[owner] = 1'b0;
            else     req_a[owner] = 1'b0;
        end
        for (int i = 0; i < 4 * bd; i++) begin
            step();
            if (toggle) req_a[1] = ~req_a[1];
            chk($sformatf("%s_frame%0d", tag, i), 32'(m_frame), 1);
            chk($sformatf("%s_sout%0d", tag, i), 32'(m_sout), 32'(word[i / bd]));
            chk($sformatf("%s_noack%0d", tag, i), 32'(m_ack), 0);
            chk($sformatf("%s_pdata%0d", tag, i), 32'(m_pd), 32'(word));
            pulses += int'(m_en && m_sh);
        end
        step();
        chk($sformatf("%s_end_frame", tag), 32'(m_frame), 0);
        chk($sformatf("%s_end_busy", tag), 32'(m_busy), 0);
        chk($sformatf("%s_pulses", tag), 32'(pulses), 3);
    endtask

    initial begin
        req_a = 2'b11;
        d0_a  = 4'hA;
        d1_a  = 4'h5;
        repeat (3) step();
        chk("rst_ack", 32'(ack_a), 0);
        chk("rst_en", 32'({en_a, sh_a}), 0);
        chk("rst_frame", 32'(frame_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_pdata", 32'(pd_a), 0);
        chk("rst_src", 32'(src_a), 1);
        chk("rst_src_b", 32'(src_b), 1);
        n_reset = 1'b1;
        for (int g = 0; g < 4; g++) begin
            expect_frame($sformatf("rr%0d", g), g[0] ? 4'h5 : 4'hA, g[0], 1'b0, 1'b1, gap);
            chk($sformatf("rr%0d_gap", g), 32'(gap), 1);
        end
        req_a = 2'b00;
        d0_a  = 4'b1011;
        step();
        req_a = 2'b01;
        expect_frame("single", 4'b1011, 1'b0, 1'b0, 1'b0, gap);
        chk("single_src", 32'(src_a), 0);
        d0_a  = 4'hC;
        d1_a  = 4'h3;
        req_a = 2'b01;
        expect_frame("tog", 4'hC, 1'b0, 1'b1, 1'b0, gap);
        req_a = 2'b00;
        step();
        chk("tog_after_ack", 32'(ack_a), 0);
        chk("tog_after_busy", 32'(busy_a), 0);
        d0_a  = 4'b0110;
        req_a = 2'b01;
        wait_load(gap);
        req_a = 2'b00;
        repeat (4) step();
        chk("mr_frame_pre", 32'(frame_a), 1);
        n_reset = 1'b0;
        #1;
        chk("mr_busy", 32'(busy_a), 0);
        chk("mr_frame", 32'(frame_a), 0);
        chk("mr_src", 32'(src_a), 1);
        chk("mr_sout", 32'(sr_a[0]), 0);
        step();
        n_reset = 1'b1;
        req_a = 2'b01;
        expect_frame("post_rst", 4'b0110, 1'b0, 1'b0, 1'b0, gap);
        chk("post_rst_gap", 32'(gap), 1);
        sel   = 1'b1;
        d1_b  = 4'b1000;
        req_b = 2'b10;
        expect_frame("bd1", 4'b1000, 1'b1, 1'b0, 1'b0, gap);
        chk("bd1_src", 32'(src_b), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
